// File: rtl/psum_requant_pack_pkg.sv
// Shared types, parameter defaults and arithmetic helpers for the psum
// requantise-and-pack slice.
package quant_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DWIDTH_DEF  = 32;
  localparam int QWIDTH_DEF  = 8;
  localparam int PACK_DEF    = 4;
  localparam int OAWIDTH_DEF = 3;
  localparam int LWIDTH_DEF  = 16;

  // Clamp a wide signed value into the range of a signed 'width'-bit number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

  // Round-half-up arithmetic right shift.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                     input logic [4:0] shift);
    logic signed [63:0] rnd;
    rnd = (shift == 5'd0) ? 64'sd0 : (64'sd1 <<< (shift - 5'd1));
    return (value + rnd) >>> shift;
  endfunction

endpackage

// File: rtl/psum_requant_pack_if.sv
// Data-path bundle of psum_requant_pack: the upstream psum stream and the
// packed output stream towards the ofmap writer.
interface psum_requant_pack_if #(
  parameter int DWIDTH = 32,
  parameter int QWIDTH = 8,
  parameter int PACK   = 4
);
  // Handshake: in_valid has no ready (upstream cannot stall, one psum per cycle
  // while high). The output stream transfers the head word on every rising clk
  // edge where out_valid && out_ready; out_valid/out_data/out_keep/out_last stay
  // stable until that transfer, and out_valid never depends on out_ready.
  logic                     in_valid;
  logic signed [DWIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [PACK*QWIDTH-1:0]   out_data;
  logic [PACK-1:0]          out_keep;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_keep, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/psum_requant_pack_requant_unit.sv
// Two-stage requantiser: bias add with saturation, then rounding shift,
// optional ReLU, zero-point add and saturation to QWIDTH.
module requant_unit
  import quant_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int QWIDTH = QWIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DWIDTH-1:0] in_data,
  input  logic signed [DWIDTH-1:0] cfg_bias,
  input  logic [4:0]               cfg_shift,
  input  logic signed [QWIDTH-1:0] cfg_zp,
  input  logic                     cfg_relu,
  output logic                     q_valid,
  output logic signed [QWIDTH-1:0] q
);

  logic                     s1_valid;
  logic signed [DWIDTH-1:0] s1;
  logic signed [63:0]       sum_w;
  logic signed [63:0]       r_w;
  logic signed [63:0]       q_w;

  // 64-bit intermediates are wide enough that no step can wrap.
  always_comb begin
    sum_w = 64'(in_data) + 64'(cfg_bias);
    r_w   = round_shift(64'(s1), cfg_shift);
    if (cfg_relu && r_w[63]) r_w = '0;
    q_w   = sat_signed(r_w + 64'(cfg_zp), QWIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      q_valid  <= 1'b0;
      q        <= '0;
    end else begin
      s1_valid <= in_valid;
      q_valid  <= s1_valid;
      if (in_valid) s1 <= DWIDTH'(sat_signed(sum_w, DWIDTH));
      if (s1_valid) q  <= QWIDTH'(q_w);
    end
  end

endmodule

// File: rtl/psum_requant_pack.sv
// Requantises finished psums, packs PACK elements per word and buffers the
// words in a show-ahead FIFO; overflow is flagged since upstream cannot stall.
module psum_requant_pack
  import quant_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int QWIDTH  = QWIDTH_DEF,
  parameter int PACK    = PACK_DEF,
  parameter int OAWIDTH = OAWIDTH_DEF,
  parameter int LWIDTH  = LWIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_load,
  input  logic signed [DWIDTH-1:0] cfg_bias,
  input  logic [4:0]               cfg_shift,
  input  logic signed [QWIDTH-1:0] cfg_zp,
  input  logic                     cfg_relu,
  input  logic [LWIDTH-1:0]        cfg_len,
  psum_requant_pack_if.slave       bus,
  output logic                     busy,
  output logic                     err_drop,
  output logic                     err_ovf,
  output state_t                   dbg_state
);

  localparam int DEPTH = 1 << OAWIDTH;
  localparam int WW    = PACK * QWIDTH;
  localparam int LANEW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int EW    = WW + PACK + 1;

  state_t                   state;
  logic signed [DWIDTH-1:0] bias_q;
  logic [4:0]               shift_q;
  logic signed [QWIDTH-1:0] zp_q;
  logic                     relu_q;
  logic [LWIDTH-1:0]        len_q;

  logic                     q_valid;
  logic signed [QWIDTH-1:0] q;

  logic                     load_ok;
  logic                     elem_fire;
  logic                     is_last;
  logic                     word_done;
  logic [LWIDTH-1:0]        elem_cnt;
  logic [LANEW-1:0]         lane;
  logic [WW-1:0]            pk_data;
  logic [WW-1:0]            word_next;
  logic [PACK-1:0]          pk_keep;
  logic [PACK-1:0]          keep_next;

  logic                     push_v;
  logic                     push_last;
  logic [WW-1:0]            push_data;
  logic [PACK-1:0]          push_keep;

  logic [EW-1:0]            mem [DEPTH];
  logic [OAWIDTH:0]         wr_ptr;
  logic [OAWIDTH:0]         rd_ptr;
  logic [EW-1:0]            head;
  logic                     empty;
  logic                     full;
  logic                     pop;
  logic                     do_write;
  logic                     ovf_drop;

  requant_unit #(
    .DWIDTH (DWIDTH),
    .QWIDTH (QWIDTH)
  ) u_requant (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid && (state == RUN)),
    .in_data   (bus.in_data),
    .cfg_bias  (bias_q),
    .cfg_shift (shift_q),
    .cfg_zp    (zp_q),
    .cfg_relu  (relu_q),
    .q_valid   (q_valid),
    .q         (q)
  );

  assign load_ok   = (state == IDLE) && cfg_load && (cfg_len != '0);
  assign elem_fire = q_valid && (state == RUN);
  assign is_last   = (elem_cnt == len_q - LWIDTH'(1));
  assign word_done = (lane == LANEW'(PACK - 1)) || is_last;
  assign dbg_state = state;

  always_comb begin
    word_next = pk_data;
    keep_next = pk_keep;
    word_next[int'(lane)*QWIDTH +: QWIDTH] = q;
    keep_next[lane] = 1'b1;
  end

  // FSM, element counter and packer. A completed word moves into the push
  // register, which writes the FIFO on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      bias_q    <= '0;
      shift_q   <= '0;
      zp_q      <= '0;
      relu_q    <= 1'b0;
      len_q     <= '0;
      elem_cnt  <= '0;
      lane      <= '0;
      pk_data   <= '0;
      pk_keep   <= '0;
      push_v    <= 1'b0;
      push_last <= 1'b0;
      push_data <= '0;
      push_keep <= '0;
      err_drop  <= 1'b0;
    end else begin
      push_v <= 1'b0;
      case (state)
        IDLE: begin
          if (load_ok) begin
            state    <= RUN;
            busy     <= 1'b1;
            bias_q   <= cfg_bias;
            shift_q  <= cfg_shift;
            zp_q     <= cfg_zp;
            relu_q   <= cfg_relu;
            len_q    <= cfg_len;
            elem_cnt <= '0;
            lane     <= '0;
            pk_data  <= '0;
            pk_keep  <= '0;
          end
        end
        RUN: begin
          if (elem_fire) begin
            elem_cnt <= elem_cnt + LWIDTH'(1);
            if (word_done) begin
              push_v    <= 1'b1;
              push_data <= word_next;
              push_keep <= keep_next;
              push_last <= is_last;
              pk_data   <= '0;
              pk_keep   <= '0;
              lane      <= '0;
            end else begin
              pk_data <= word_next;
              pk_keep <= keep_next;
              lane    <= lane + LANEW'(1);
            end
            if (is_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (load_ok) err_drop <= 1'b0;
      if (bus.in_valid && (state == IDLE)) err_drop <= 1'b1;
    end
  end

  // Output FIFO; pointers carry a wrap bit so full and empty are distinct.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[OAWIDTH] != rd_ptr[OAWIDTH]) &&
                    (wr_ptr[OAWIDTH-1:0] == rd_ptr[OAWIDTH-1:0]);
  assign pop      = !empty && bus.out_ready;
  assign do_write = push_v && (!full || pop);
  assign ovf_drop = push_v && full && !pop;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[OAWIDTH-1:0]] <= {push_last, push_keep, push_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + (OAWIDTH + 1)'(1);
      if (pop)      rd_ptr <= rd_ptr + (OAWIDTH + 1)'(1);
      if (load_ok)  err_ovf <= 1'b0;
      if (ovf_drop) err_ovf <= 1'b1;
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign head          = mem[rd_ptr[OAWIDTH-1:0]];
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : head[WW-1:0];
  assign bus.out_keep  = empty ? '0 : head[WW +: PACK];
  assign bus.out_last  = !empty && head[EW-1];

endmodule

// File: tb/tb_psum_requant_pack.sv
// Bench for psum_requant_pack: directed frames plus randomized frames scored
// against an arithmetic reference model through an expected-word queue.
module tb_psum_requant_pack;
  import quant_pkg::*;

  localparam int DW    = 32;
  localparam int QW    = 8;
  localparam int PK    = 4;
  localparam int OAW   = 3;
  localparam int LW    = 16;
  localparam int DEPTH = 1 << OAW;
  localparam int WW    = PK * QW;
  localparam int EW    = WW + PK + 1;
  localparam longint S32_MAX = 64'sd2147483647;
  localparam longint S32_MIN = -64'sd2147483647 - 64'sd1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_load;
  logic signed [DW-1:0] cfg_bias;
  logic [4:0]           cfg_shift;
  logic signed [QW-1:0] cfg_zp;
  logic                 cfg_relu;
  logic [LW-1:0]        cfg_len;
  logic                 busy;
  logic                 err_drop;
  logic                 err_ovf;
  state_t               dbg_state;

  psum_requant_pack_if #(.DWIDTH(DW), .QWIDTH(QW), .PACK(PK)) bus();

  psum_requant_pack #(
    .DWIDTH(DW), .QWIDTH(QW), .PACK(PK), .OAWIDTH(OAW), .LWIDTH(LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_bias  (cfg_bias),
    .cfg_shift (cfg_shift),
    .cfg_zp    (cfg_zp),
    .cfg_relu  (cfg_relu),
    .cfg_len   (cfg_len),
    .bus       (bus),
    .busy      (busy),
    .err_drop  (err_drop),
    .err_ovf   (err_ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_words = 0;
  int            rdy_mode = 1;   // 0 hold low, 1 always ready, 2 random
  logic [EW-1:0] exp_q[$];
  int            data_buf[$];
  int            cur_bias;
  int            cur_shift;
  int            cur_zp;
  bit            cur_relu;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint floor_div(input longint a, input longint d);
    longint r;
    r = a / d;
    if ((a % d != 0) && (a < 0)) r = r - 1;
    return r;
  endfunction

  function automatic logic [QW-1:0] ref_q(input int psum);
    longint s, d, r, v;
    s = longint'(psum) + longint'(cur_bias);
    if (s > S32_MAX) s = S32_MAX;
    if (s < S32_MIN) s = S32_MIN;
    if (cur_shift == 0) r = s;
    else begin
      d = longint'(1) << cur_shift;
      r = floor_div(s + d / 2, d);
    end
    if (cur_relu && r < 0) r = 0;
    v = r + longint'(cur_zp);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return QW'(v);
  endfunction

  // Queues the words the current data_buf frame should produce, first max_words only.
  task automatic expect_frame(input int max_words);
    logic [WW-1:0] word;
    logic [PK-1:0] keep;
    int lane, nw;
    word = '0; keep = '0; lane = 0; nw = 0;
    for (int i = 0; i < data_buf.size(); i++) begin
      word[lane*QW +: QW] = ref_q(data_buf[i]);
      keep[lane] = 1'b1;
      lane++;
      if (lane == PK || i == data_buf.size() - 1) begin
        if (nw < max_words) exp_q.push_back({(i == data_buf.size() - 1), keep, word});
        nw++;
        word = '0; keep = '0; lane = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int bias, input int shift, input int zp, input bit relu, input int len);
    cfg_bias  = DW'(bias);
    cfg_shift = 5'(shift);
    cfg_zp    = QW'(zp);
    cfg_relu  = relu;
    cfg_len   = LW'(len);
    cfg_load  = 1'b1;
    tick();
    cfg_load  = 1'b0;
  endtask

  task automatic start_frame(input int bias, input int shift, input int zp, input bit relu, input int len);
    cur_bias = bias; cur_shift = shift; cur_zp = zp; cur_relu = relu;
    do_load(bias, shift, zp, relu, len);
  endtask

  task automatic send_elems(input int gap_max);
    for (int i = 0; i < data_buf.size(); i++) begin
      if (gap_max > 0) begin
        bus.in_valid = 1'b0;
        tick($urandom_range(0, gap_max));
      end
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(data_buf[i]);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    tick(4);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- ready driver ----------------
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_words++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word",
                 {bus.out_last, bus.out_keep, bus.out_data});
      end else begin
        check("out_word", 64'({bus.out_last, bus.out_keep, bus.out_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int w0;
    rst = 1'b1;
    cfg_load = 1'b0; cfg_bias = '0; cfg_shift = '0; cfg_zp = '0; cfg_relu = 1'b0; cfg_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    tick(3);
    rst = 1'b0;
    tick();

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err_drop", err_drop, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_state", dbg_state, IDLE);

    // passthrough and pipeline latency
    start_frame(0, 0, 0, 0, 4);
    check("pt_busy", busy, 1);
    data_buf = '{1, 2, 3, 4};
    exp_q.push_back({1'b1, 4'b1111, 32'h04030201});
    send_elems(0);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check("pt_latency", 64'(lat), 64'd4);
    wait_drain("pt_drain");
    check("pt_idle", busy, 0);

    // rounding and saturation
    start_frame(10, 4, 0, 0, 4);
    data_buf = '{22, 1000, -1000, 5000};
    exp_q.push_back({1'b1, 4'b1111, 32'h7FC23F02});
    send_elems(1);
    wait_drain("round_drain");

    // stage-1 saturation must not wrap
    start_frame(100, 24, -128, 0, 1);
    data_buf = '{2147483632};
    exp_q.push_back({1'b1, 4'b0001, 32'h00000000});
    send_elems(0);
    wait_drain("sat1_drain");

    // ReLU with zero point, partial final word
    start_frame(0, 0, 5, 1, 2);
    data_buf = '{-7, 3};
    exp_q.push_back({1'b1, 4'b0011, 32'h00000805});
    send_elems(0);
    wait_drain("relu_drain");

    // overflow under stalled output
    rdy_mode = 0;
    tick(2);
    start_frame(0, 0, 0, 0, 4 * (DEPTH + 1));
    data_buf.delete();
    for (int i = 0; i < 4 * (DEPTH + 1); i++) data_buf.push_back(i + 1);
    expect_frame(DEPTH);
    send_elems(0);
    tick(8);
    check("ovf_flag", err_ovf, 1);
    check("ovf_head_valid", bus.out_valid, 1);
    check("ovf_idle", busy, 0);
    w0 = n_words;
    rdy_mode = 1;
    wait_drain("ovf_drain");
    check("ovf_words_kept", 64'(n_words - w0), 64'(DEPTH));
    start_frame(0, 0, 0, 0, 4);
    check("ovf_cleared", err_ovf, 0);
    data_buf = '{1, 2, 3, 4};
    exp_q.push_back({1'b1, 4'b1111, 32'h04030201});
    send_elems(0);
    wait_drain("ovf_next_drain");

    // protocol: input while idle, zero-length load, load during run
    w0 = n_words;
    bus.in_valid = 1'b1; bus.in_data = 32'd55;
    tick();
    bus.in_valid = 1'b0;
    tick(10);
    check("idle_err_drop", err_drop, 1);
    check("idle_no_output", 64'(n_words - w0), 64'd0);
    do_load(0, 0, 0, 0, 0);
    check("len0_busy", busy, 0);
    check("len0_keeps_drop", err_drop, 1);
    start_frame(0, 0, 0, 0, 4);
    check("load_clears_drop", err_drop, 0);
    exp_q.push_back({1'b1, 4'b1111, 32'h04030201});
    data_buf = '{1, 2};
    send_elems(0);
    do_load(100, 3, 7, 1, 1);
    check("run_load_ignored", dbg_state, RUN);
    data_buf = '{3, 4};
    send_elems(0);
    wait_drain("run_load_drain");

    // reset in the middle of a frame
    start_frame(0, 0, 0, 0, 4);
    data_buf = '{9, 10};
    send_elems(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", busy, 0);
    w0 = n_words;
    tick(10);
    check("midrst_no_output", 64'(n_words - w0), 64'd0);
    start_frame(0, 0, 0, 0, 4);
    data_buf = '{1, 2, 3, 4};
    exp_q.push_back({1'b1, 4'b1111, 32'h04030201});
    send_elems(0);
    wait_drain("midrst_next_drain");

    // randomized frames against the reference model
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int b, len;
      case ($urandom_range(0, 2))
        0:       b = 0;
        1:       b = int'($urandom_range(0, 2000)) - 1000;
        default: b = int'($urandom());
      endcase
      len = $urandom_range(1, 20);
      data_buf.delete();
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0:       data_buf.push_back(int'($urandom()));
          1:       data_buf.push_back(int'($urandom_range(0, 4000)) - 2000);
          2:       data_buf.push_back(32'sh7FFFFFFF - int'($urandom_range(0, 50)));
          default: data_buf.push_back(32'sh80000000 + int'($urandom_range(0, 50)));
        endcase
      end
      start_frame(b, $urandom_range(0, 31), int'($urandom_range(0, 255)) - 128,
                  1'($urandom_range(0, 1)), len);
      expect_frame(1000);
      send_elems(2);
      wait_drain("rand_drain");
      check("rand_no_ovf", err_ovf, 0);
      check("rand_no_drop", err_drop, 0);
    end

    rdy_mode = 1;
    tick(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
